// File: rtl/audio_pkg.sv
// audio_pkg: shared defaults, FSM encoding and gain helpers for the audio gain path
package audio_pkg;
    localparam int DW_DEF  = 20;
    localparam int NCH_DEF = 2;
    localparam int GW_DEF  = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
    function automatic int unity_gain(input int gw);
        return 1 << gw;
    endfunction
endpackage

// File: rtl/audio_gain_mul.sv
// audio_gain_mul: registered signed sample x unsigned gain, floor-shifted by GW and truncated to DW
module audio_gain_mul
    import audio_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int GW = GW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a_i,
    input  logic [GW:0]   g_i,
    output logic [DW-1:0] y_o
);
    logic signed [DW+GW+1:0] a_x, g_x, p;
    logic [DW-1:0] y_d, y_q;
    assign a_x = {{(GW+2){a_i[DW-1]}}, a_i};
    assign g_x = {{(DW+1){1'b0}}, g_i};
    assign p   = a_x * g_x;
    assign y_d = DW'(p >>> GW);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) y_q <= '0;
        else     y_q <= y_d;
    end
    assign y_o = y_q;
endmodule

// File: rtl/audio_gain_ctrl.sv
// audio_gain_ctrl: stepped volume and soft-mute ramp over NCH channels,
// sharing one multiplier across channels under a small FSM.
module audio_gain_ctrl
    import audio_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int NCH      = NCH_DEF,
    parameter int GW       = GW_DEF,
    parameter int VOL_INIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vol_up_pls,
    input  logic              vol_dn_pls,
    input  logic              mute_pls,
    input  logic              iAudio_sync,
    input  logic [NCH*DW-1:0] iAudio,
    output logic              oAudio_sync,
    output logic [NCH*DW-1:0] oAudio,
    output logic [GW:0]       oVolume,
    output logic              oMuted,
    output logic              oOverrun,
    output logic [7:0]        tp
);
    localparam logic [GW:0] UNITY = (GW+1)'(unity_gain(GW));
    state_t state_q, state_d;
    logic [2:0] ch_q, ch_d;
    logic [GW:0] vol_q, vol_d, gain_q, gain_d, target;
    logic muted_q, muted_d, ovr_q, ovr_d, osync_q, osync_d;
    logic [NCH*DW-1:0] smp_q, smp_d, buf_q, buf_d, out_q, out_d;
    logic [DW-1:0] mul_y;

    audio_gain_mul #(.DW(DW), .GW(GW)) u_mul (
        .clk (clk),
        .rst (rst),
        .a_i (smp_q[ch_q*DW +: DW]),
        .g_i (gain_q),
        .y_o (mul_y)
    );

    assign target = muted_q ? '0 : vol_q;

    always_comb begin
        vol_d   = (vol_up_pls && !vol_dn_pls && vol_q != UNITY) ? vol_q + 1'b1 :
                  (vol_dn_pls && !vol_up_pls && vol_q != '0)    ? vol_q - 1'b1 : vol_q;
        muted_d = muted_q ^ mute_pls;
        ovr_d   = ovr_q | (iAudio_sync && state_q != IDLE);
        state_d = state_q;
        ch_d    = ch_q;
        smp_d   = smp_q;
        gain_d  = gain_q;
        buf_d   = buf_q;
        out_d   = out_q;
        osync_d = 1'b0;
        case (state_q)
            IDLE: if (iAudio_sync) begin
                state_d = MUL;
                smp_d   = iAudio;
                ch_d    = '0;
                gain_d  = (gain_q < target) ? gain_q + 1'b1 :
                          (gain_q > target) ? gain_q - 1'b1 : gain_q;
            end
            MUL: begin
                // the multiplier result lags its channel index by one cycle
                if (ch_q != '0) buf_d[(ch_q - 3'd1)*DW +: DW] = mul_y;
                ch_d = ch_q + 1'b1;
                if (ch_q == 3'(NCH-1)) state_d = DONE;
            end
            DONE: begin
                buf_d[(NCH-1)*DW +: DW] = mul_y;
                out_d   = buf_d;
                osync_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            vol_q   <= (GW+1)'(VOL_INIT);
            gain_q  <= (GW+1)'(VOL_INIT);
            muted_q <= 1'b0;
            ovr_q   <= 1'b0;
            osync_q <= 1'b0;
            smp_q   <= '0;
            buf_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            vol_q   <= vol_d;
            gain_q  <= gain_d;
            muted_q <= muted_d;
            ovr_q   <= ovr_d;
            osync_q <= osync_d;
            smp_q   <= smp_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
        end
    end

    assign oAudio_sync = osync_q;
    assign oAudio      = out_q;
    assign oVolume     = vol_q;
    assign oMuted      = muted_q;
    assign oOverrun    = ovr_q;
    assign tp          = {state_q, ch_q, muted_q, ovr_q, gain_q == target};
endmodule

// File: tb/tb_audio_gain_ctrl.sv
// tb_audio_gain_ctrl: 2- and 4-channel builds checked against a cycle-level arithmetic model
module tb_audio_gain_ctrl;
    localparam int DW = 20;
    localparam int NC[2] = '{2, 4};

    logic clk = 0, rst = 1, up = 0, dn = 0, mute = 0, sync = 0;
    logic [4*DW-1:0] ia4 = '0;
    logic [2*DW-1:0] oa2;
    logic [4*DW-1:0] oa4;
    logic os2, os4, om2, om4, oo2, oo4;
    logic [4:0] ov2, ov4;
    logic [7:0] tp2, tp4;
    int errors = 0, checks = 0;
    bit run = 0;

    always #5 clk = ~clk;

    audio_gain_ctrl #(.DW(DW), .NCH(2), .GW(4), .VOL_INIT(16)) dut2 (
        .clk(clk), .rst(rst), .vol_up_pls(up), .vol_dn_pls(dn), .mute_pls(mute),
        .iAudio_sync(sync), .iAudio(ia4[2*DW-1:0]), .oAudio_sync(os2), .oAudio(oa2),
        .oVolume(ov2), .oMuted(om2), .oOverrun(oo2), .tp(tp2)
    );
    audio_gain_ctrl #(.DW(DW), .NCH(4), .GW(4), .VOL_INIT(16)) dut4 (
        .clk(clk), .rst(rst), .vol_up_pls(up), .vol_dn_pls(dn), .mute_pls(mute),
        .iAudio_sync(sync), .iAudio(ia4), .oAudio_sync(os4), .oAudio(oa4),
        .oVolume(ov4), .oMuted(om4), .oOverrun(oo4), .tp(tp4)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] scale(input logic [159:0] s, input int n, input int g);
        logic [159:0] r = '0;
        logic signed [DW-1:0] x;
        longint p, q;
        for (int k = 0; k < n; k++) begin
            x = s[k*DW +: DW];
            p = longint'(x) * g;
            q = (p >= 0) ? p / 16 : -((-p + 15) / 16);
            r[k*DW +: DW] = q[DW-1:0];
        end
        return r;
    endfunction

    int m_vol = 16, cyc = 0, tgt;
    bit m_mute = 0;
    int m_gain[2] = '{16, 16}, m_free[2] = '{0, 0}, m_due[2] = '{-1, -1};
    bit m_ovr[2] = '{0, 0}, m_sync[2] = '{0, 0};
    logic [159:0] m_out[2] = '{160'd0, 160'd0}, m_pend[2] = '{160'd0, 160'd0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vol = 16;
            m_mute = 0;
            for (int i = 0; i < 2; i++) begin
                m_gain[i] = 16; m_free[i] = 0; m_due[i] = -1;
                m_ovr[i] = 0; m_sync[i] = 0; m_out[i] = '0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                m_sync[i] = (m_due[i] == cyc);
                if (m_sync[i]) m_out[i] = m_pend[i];
                if (sync && cyc < m_free[i]) m_ovr[i] = 1;
                else if (sync) begin
                    tgt = m_mute ? 0 : m_vol;
                    m_gain[i] += (m_gain[i] < tgt) ? 1 : (m_gain[i] > tgt) ? -1 : 0;
                    m_pend[i] = scale(160'(ia4), NC[i], m_gain[i]);
                    m_due[i]  = cyc + NC[i] + 1;
                    m_free[i] = cyc + NC[i] + 2;
                end
            end
            if (up && !dn && m_vol < 16) m_vol++;
            if (dn && !up && m_vol > 0) m_vol--;
            m_mute ^= mute;
        end
    end

    always @(negedge clk) if (run) begin
        chk("sync2", os2, m_sync[0]);
        chk("audio2", oa2, m_out[0]);
        chk("ovr2", oo2, m_ovr[0]);
        chk("vol2", ov2, m_vol);
        chk("mute2", om2, m_mute);
        chk("sync4", os4, m_sync[1]);
        chk("audio4", oa4, m_out[1]);
        chk("ovr4", oo4, m_ovr[1]);
        chk("vol4", ov4, m_vol);
        chk("mute4", om4, m_mute);
    end

    task automatic pls(input logic u, input logic d, input logic m);
        up = u; dn = d; mute = m;
        @(negedge clk);
        up = 0; dn = 0; mute = 0;
    endtask

    task automatic send(input logic [4*DW-1:0] d);
        ia4 = d; sync = 1;
        @(negedge clk);
        sync = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_rst();
        #1 rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    int l2, l4, n;
    initial begin
        repeat (2) @(negedge clk);
        rst = 0; run = 1;
        chk("rst_audio", oa2, 0);
        chk("rst_sync", os2, 0);
        chk("rst_vol", ov2, 16);
        chk("rst_mute", om2, 0);
        chk("rst_ovr", oo2, 0);
        chk("rst_tp", tp2, 8'h01);

        ia4 = {20'h80000, 20'h7FFFF, 20'hFFFFF, 20'h12345}; sync = 1;
        @(negedge clk);
        sync = 0; l2 = -1; l4 = -1;
        for (int k = 0; k <= 10; k++) begin
            if (os2 && l2 < 0) l2 = k;
            if (os4 && l4 < 0) l4 = k;
            @(negedge clk);
        end
        chk("lat2", l2, 3);
        chk("lat4", l4, 5);
        chk("unity2", oa2, {20'hFFFFF, 20'h12345});
        chk("unity4", oa4, {20'h80000, 20'h7FFFF, 20'hFFFFF, 20'h12345});

        repeat (8) pls(0, 1, 0);
        chk("vol_dn", ov2, 8);
        for (int k = 1; k <= 10; k++) begin
            send({60'h0, 20'h10000});
            chk("ramp_dn", oa2[19:0], (k <= 8) ? 20'h1000 * (16 - k) : 20'h08000);
        end
        send({40'h0, 20'hFFFFD, 20'hFFFFF});
        chk("neg_floor", oa2, {20'hFFFFE, 20'hFFFFF});

        repeat (8) pls(1, 0, 0);
        repeat (8) send(80'({$urandom, $urandom, $urandom}));
        pls(0, 0, 1);
        chk("muted", om2, 1);
        for (int k = 1; k <= 20; k++) begin
            send({60'h0, 20'h00100});
            chk("ramp_mute", oa2[19:0], (k <= 16) ? 20'h10 * (16 - k) : 20'h0);
        end
        repeat (17) pls(1, 0, 0);
        chk("vol_sat", ov2, 16);
        send({40'h0, 20'h80000, 20'h00100});
        chk("mute_zero", oa2, 0);

        pls(0, 0, 1);
        pls(0, 1, 0);
        pls(1, 1, 0);
        chk("both_pls", ov2, 15);
        chk("unmuted", om2, 0);

        ia4 = 80'({$urandom, $urandom, $urandom}); sync = 1;
        repeat (2) @(negedge clk);
        sync = 0; n = 0;
        repeat (12) begin
            if (os2) n++;
            @(negedge clk);
        end
        chk("ovr_pulses", n, 1);
        chk("ovr_flag2", oo2, 1);
        chk("ovr_flag4", oo4, 1);

        ia4 = 80'({$urandom, $urandom, $urandom}); sync = 1;
        @(negedge clk);
        sync = 0;
        do_rst();
        chk("mid_rst_audio", oa2, 0);
        chk("mid_rst_sync", os2, 0);
        chk("mid_rst_ovr", oo2, 0);
        n = 0;
        repeat (8) begin
            if (os2) n++;
            @(negedge clk);
        end
        chk("mid_rst_pulses", n, 0);

        repeat (600) begin
            n = $urandom_range(0, 99);
            ia4 = 80'({$urandom, $urandom, $urandom});
            up = n < 5; dn = n >= 5 && n < 10; mute = n == 10 || n == 11;
            sync = $urandom_range(0, 3) == 0;
            @(negedge clk);
            up = 0; dn = 0; mute = 0; sync = 0;
            if ($urandom_range(0, 299) == 0) do_rst();
        end
        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/audio_gain_ctrl.md
Name: audio_gain_ctrl

Overview:
- Parametrised per-sample volume/mute stage for the audio path, between the audio codec receive side and the codec transmit side.
- Generalises the fixed 2-channel, 20-bit hard-mute pass-through to NCH channels of DW bits.
- Adds stepped volume, a click-free soft-mute ramp, and a single time-multiplexed multiplier sequenced by an FSM.
- Button pulses come from the existing button_detector, instantiated outside this block.

Parameters:
- DW, 20, signed sample width per channel.
- NCH, 2, channel count, range 1..8.
- GW, 4, gain fraction bits; unity gain = 2**GW.
- VOL_INIT, 16, volume after reset, range 0..2**GW.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- vol_up_pls  in  1  one-cycle pulse: volume +1.
- vol_dn_pls  in  1  one-cycle pulse: volume -1.
- mute_pls  in  1  one-cycle pulse: toggle mute.
- iAudio_sync  in  1  one-cycle pulse: iAudio valid.
- iAudio  in  NCH*DW  channel k at bits [k*DW +: DW], two's complement.
- oAudio_sync  out  1  one-cycle pulse: oAudio updated.
- oAudio  out  NCH*DW  processed samples, same packing as iAudio.
- oVolume  out  GW+1  current volume setting.
- oMuted  out  1  mute mode.
- oOverrun  out  1  sticky flag: an input sync was dropped.
- tp  out  8  test point: {state[1:0], ch_idx[2:0], oMuted, oOverrun, gain_at_target}.

Behaviour:
- Reset values:
  - oAudio_sync=0, oAudio=0, oVolume=VOL_INIT, oMuted=0, oOverrun=0.
  - cur_gain=VOL_INIT, state=IDLE.
- Volume control:
  - vol_up_pls increments oVolume, saturating at 2**GW.
  - vol_dn_pls decrements oVolume, saturating at 0.
  - Both pulses in the same cycle: no change.
  - Volume still changes while muted.
- Mute control: mute_pls toggles oMuted.
- Target gain: target = oMuted ? 0 : oVolume.
- FSM states: IDLE, MUL, DONE.
  - IDLE: on iAudio_sync, latch all of iAudio into sample buffer, set cur_gain to one step toward target (+1, -1 or hold), set ch_idx=0, go to MUL.
  - MUL: one channel per cycle. out_buf[ch_idx] = (sample[ch_idx] * cur_gain) >>> GW, using a signed DW x unsigned GW+1 product with an arithmetic shift (floor), truncated to DW bits. No overflow is possible because cur_gain is at most unity. After ch_idx=NCH-1, go to DONE.
  - DONE: copy out_buf to oAudio, pulse oAudio_sync for one cycle, go to IDLE.
- Latency: sync at cycle T gives oAudio and oAudio_sync at T+NCH+1. oAudio holds between pulses.
- Minimum sync spacing is NCH+2 cycles.
  - iAudio_sync while not in IDLE is dropped and sets oOverrun, which stays set until rst.
  - Processing of the current sample is unaffected.
- Ramp: cur_gain moves at most 1 step per accepted sample.
  - Full mute from unity takes 2**GW samples; no output discontinuity larger than one gain step.
  - cur_gain is not visible at a port.
- Gain 2**GW yields output == input bit-exact.
- Gain 0 yields output 0, including negative samples.
- Reset mid-operation: asynchronous return to reset values; a partial sample is discarded and no oAudio_sync is produced.

Decomposition:
- Shared package audio_pkg holds:
  - FSM state encoding constants (IDLE=0, MUL=1, DONE=2).
  - Default DW/NCH/GW values.
  - A function for unity gain.
- One sub-module, audio_gain_mul: a registered signed-by-unsigned multiply with shift and truncate, one cycle latency, reused per channel. The FSM accounts for its latency in the MUL count.

Test Plan:
- Reset, then sync with L=20'h12345, R=20'hFFFFF (-1) -> oAudio_sync at T+3, oAudio identical to input (unity), oVolume=16.
- 8 vol_dn_pls, then 8 syncs with constant L=20'h10000 -> cur_gain ramps 16 to 8, one step per sample; L outputs 20'h0F000, 20'h0E000, ..., 20'h08000, then steady.
- mute_pls at unity, then 20 syncs with L=20'h00100 -> L steps down by 20'h010 per sample, reaching 0 at the 16th sample; oMuted=1; 17 vol_up_pls while muted leave oVolume saturated at 16 and output still 0.
- Negative rounding: gain 8, sample 20'hFFFFF (-1) -> output 20'hFFFFF (floor of -0.5); sample -3 -> -2.
- Overrun: second iAudio_sync 1 cycle after the first -> oOverrun=1 (sticky), exactly one oAudio_sync emitted, first sample's result correct.
- Simultaneous vol_up_pls and vol_dn_pls -> oVolume unchanged; rst asserted during MUL -> no oAudio_sync, oAudio=0; NCH=4 build -> latency 5 cycles, per-channel independence checked.
